wide_op_seq: RTL
================

# wide_op_seq

Multi-cycle 16-bit operation sequencer that sits on the initiating side of the 8-bit combinational ALU. It accepts one 16-bit operation and drives the ALU's INPUTA/INPUTB/OP/C_IN/S_IN for two byte passes. Between passes it chains carry or shift bits from the ALU's C_OUT/S_OUT. It then returns a 16-bit result with carry and zero flags. It provides double-precision arithmetic for the processor without widening the datapath.

## Interface

Parameters: none. Opcode encodings are the `op_mne` values from package `definitions` (kADD, kSUB, kSHL, kSHR, kXOR, kAND, kOR, kPASS).

- CLK  in  1  sole clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  request; sampled only in IDLE
- OP_IN  in  3  operation (op_mne)
- A16  in  16  operand A
- B16  in  16  operand B (ignored for kSHL/kSHR)
- ALU_A  out  8  to ALU INPUTA
- ALU_B  out  8  to ALU INPUTB
- ALU_OP  out  3  to ALU OP
- ALU_C_IN  out  1  to ALU C_IN
- ALU_S_IN  out  1  to ALU S_IN
- ALU_OUT  in  8  from ALU OUT
- ALU_C_OUT  in  1  from ALU C_OUT
- ALU_S_OUT  in  1  from ALU S_OUT
- ALU_ZERO  in  1  from ALU ZERO
- BUSY  out  1  high in P1 and P2
- DONE  out  1  one-cycle completion pulse
- RESULT  out  16  registered result
- CARRY  out  1  registered carry / shifted-out bit
- ZERO16  out  1  registered, 1 iff RESULT == 0

## Operation

- FSM states: IDLE, P1, P2.
  - IDLE & START: latch OP_IN/A16/B16, go to P1.
  - P1: go to P2.
  - P2: go to IDLE.
- ALU drive is combinational from state and latched operands. In IDLE: ALU_A=0, ALU_B=0, ALU_OP=kPASS, ALU_C_IN=0, ALU_S_IN=0.
- Each pass captures ALU_OUT and ALU_C_OUT/ALU_S_OUT/ALU_ZERO on the edge that leaves the pass state.
- Per-op pass plan (P1 byte, P2 byte):
  - kADD: low then high. ALU_OP=kADD. C_IN=0 in P1; C_IN=captured P1 C_OUT in P2. CARRY = P2 C_OUT.
  - kSUB: ALU kSUB forces C_OUT=0, so the sequencer issues kADD with ALU_B = ~B byte. C_IN=1 in P1 and chains as for kADD. CARRY = P2 C_OUT (1 = no borrow).
  - kSHL: low then high. ALU_OP=kSHL, ALU_B=8'd1 (single-bit mode). S_IN=0 in P1; S_IN=P1 S_OUT in P2. CARRY = P2 S_OUT (old A16[15]).
  - kSHR: high then low. ALU_OP=kSHR, ALU_B=8'd1. S_IN=0 in P1; S_IN=P1 S_OUT in P2. CARRY = P2 S_OUT (old A16[0]).
  - kXOR/kAND/kOR/kPASS: low then high, independent passes, ALU_OP=op, C_IN=S_IN=0. CARRY=0.
- ZERO16 = P1 ALU_ZERO AND P2 ALU_ZERO.
- RESULT/CARRY/ZERO16 update only at the P2→IDLE edge and hold until the next completion.

## Timing

- Reset (async, immediate): state=IDLE, RESULT=0, CARRY=0, ZERO16=0, BUSY=0, DONE=0, latched operands=0, ALU drive at IDLE defaults.
- Latency: START sampled at edge 0 → P1 during cycle 1, P2 during cycle 2. At edge 3 the registered results are valid and DONE=1 for exactly cycle 3.
- BUSY=1 in cycles 1–2.
- START while BUSY: ignored, no queuing. Operand changes after edge 0 have no effect.
- START during the DONE cycle is accepted, since the state is IDLE. Back-to-back throughput is one op per 3 cycles.
- Reset asserted mid-op: the operation is aborted, no DONE, all outputs return to reset values.
- The ALU is combinational. One full pass (sequencer drive → ALU → capture) must close in one CLK period.

## Test plan

- ADD A16=0x00FF, B16=0x0001 → RESULT=0x0100, CARRY=0, ZERO16=0. DONE exactly 3 edges after START; BUSY high for 2 cycles.
- ADD 0xFFFF + 0x0001 → RESULT=0x0000, CARRY=1, ZERO16=1. SUB 0x1000 − 0x0001 → 0x0FFF, CARRY=1. SUB 0x0000 − 0x0001 → 0xFFFF, CARRY=0.
- SHL A16=0x8080 → RESULT=0x0100, CARRY=1. SHR A16=0x0101 → RESULT=0x0080, CARRY=1. Check ALU_B=1 and the S_IN chain in P2.
- XOR 0xA5A5 ^ 0xA5A5 → RESULT=0x0000, ZERO16=1, CARRY=0. PASS B16=0x1234 → RESULT=0x1234.
- START pulsed again during P1 with different operands → ignored, first result unchanged. START held through the DONE cycle → second op starts, DONE 3 edges later.
- Assert RST_N low during P2 of an ADD → BUSY/DONE/RESULT/CARRY/ZERO16 go 0 immediately, no DONE. After release, ADD 0x0001 + 0x0001 → 0x0002.

Source files
------------

// File: rtl/wide_op_seq.sv
// 16-bit operation sequencer driving an 8-bit combinational ALU in two byte passes.
// Chains carry/shift bits between passes and returns a registered 16-bit result.
package definitions;
    typedef enum logic [2:0] {
        kADD  = 3'd0,
        kSUB  = 3'd1,
        kSHL  = 3'd2,
        kSHR  = 3'd3,
        kXOR  = 3'd4,
        kAND  = 3'd5,
        kOR   = 3'd6,
        kPASS = 3'd7
    } op_mne;
endpackage

module wide_op_seq
    import definitions::*;
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        START,
    input  op_mne       OP_IN,
    input  logic [15:0] A16,
    input  logic [15:0] B16,
    output logic [7:0]  ALU_A,
    output logic [7:0]  ALU_B,
    output op_mne       ALU_OP,
    output logic        ALU_C_IN,
    output logic        ALU_S_IN,
    input  logic [7:0]  ALU_OUT,
    input  logic        ALU_C_OUT,
    input  logic        ALU_S_OUT,
    input  logic        ALU_ZERO,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] RESULT,
    output logic        CARRY,
    output logic        ZERO16
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        P1   = 2'd1,
        P2   = 2'd2
    } state_t;

    state_t      state, state_d;
    op_mne       op_q;
    logic [15:0] a_q, b_q;
    logic [7:0]  p1_out;
    logic        p1_c, p1_s, p1_z;
    logic        in_p2, hi_sel;
    logic [7:0]  a_byte, b_byte;
    logic        carry_d;

    assign in_p2  = (state == P2);
    // Right shifts walk from the high byte down so the shifted bit flows low.
    assign hi_sel = in_p2 ^ (op_q == kSHR);
    assign a_byte = hi_sel ? a_q[15:8] : a_q[7:0];
    assign b_byte = hi_sel ? b_q[15:8] : b_q[7:0];
    assign BUSY   = (state != IDLE);

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (START) state_d = P1;
            P1:      state_d = P2;
            P2:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ALU_A    = 8'd0;
        ALU_B    = 8'd0;
        ALU_OP   = kPASS;
        ALU_C_IN = 1'b0;
        ALU_S_IN = 1'b0;
        if (state != IDLE) begin
            ALU_A  = a_byte;
            ALU_B  = b_byte;
            ALU_OP = op_q;
            unique case (op_q)
                kADD: ALU_C_IN = in_p2 & p1_c;
                kSUB: begin
                    // ALU subtract drops the borrow, so use A + ~B + 1.
                    ALU_OP   = kADD;
                    ALU_B    = ~b_byte;
                    ALU_C_IN = in_p2 ? p1_c : 1'b1;
                end
                kSHL, kSHR: begin
                    ALU_B    = 8'd1;
                    ALU_S_IN = in_p2 & p1_s;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        carry_d = 1'b0;
        unique case (op_q)
            kADD, kSUB: carry_d = ALU_C_OUT;
            kSHL, kSHR: carry_d = ALU_S_OUT;
            default:    carry_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= IDLE;
            op_q   <= kADD;
            a_q    <= 16'd0;
            b_q    <= 16'd0;
            p1_out <= 8'd0;
            p1_c   <= 1'b0;
            p1_s   <= 1'b0;
            p1_z   <= 1'b0;
            RESULT <= 16'd0;
            CARRY  <= 1'b0;
            ZERO16 <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            state <= state_d;
            DONE  <= in_p2;
            if (state == IDLE && START) begin
                op_q <= OP_IN;
                a_q  <= A16;
                b_q  <= B16;
            end
            if (state == P1) begin
                p1_out <= ALU_OUT;
                p1_c   <= ALU_C_OUT;
                p1_s   <= ALU_S_OUT;
                p1_z   <= ALU_ZERO;
            end
            if (in_p2) begin
                RESULT <= (op_q == kSHR) ? {p1_out, ALU_OUT}
                                         : {ALU_OUT, p1_out};
                CARRY  <= carry_d;
                ZERO16 <= p1_z & ALU_ZERO;
            end
        end
    end

endmodule
